dir_sequencer: RTL

DIR_SEQUENCER -- requirements
Module: dir_sequencer

---
 rtl/dir_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dir_sequencer.sv
// dir_sequencer: requests a path from an external planner, loads the packed
// direction codes and plays them out one slot at a time, advancing either on
// a fixed cycle timer or on node-detected pulses.
// Optional feature: define DIR_SEQ_AUTO_REPLAN_EN to make the block bump both
// node indices (mod NUM_NODES) after each completed path and immediately
// request the next one, sweeping continuously until reset.
module dir_sequencer #(
  parameter int MAX_STEPS = 10,
  parameter int DIR_W     = 2,
  parameter int NODE_W    = 5,
  parameter int NUM_NODES = 25,
  parameter int START_CYC = 200,
  parameter int TICK_DIV  = 50000000,
  parameter int WAIT_TO   = 1000000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             go,
  input  logic [NODE_W-1:0]                s_node_in,
  input  logic [NODE_W-1:0]                e_node_in,
  input  logic                             adv_mode,
  input  logic                             node_hit,
  output logic                             plan_start,
  output logic [NODE_W-1:0]                plan_s_node,
  output logic [NODE_W-1:0]                plan_e_node,
  input  logic                             plan_done,
  input  logic [MAX_STEPS*DIR_W-1:0]       plan_path,
  output logic [DIR_W-1:0]                 dir_out,
  output logic                             dir_valid,
  output logic [$clog2(MAX_STEPS+1)-1:0]   step_idx,
  output logic                             busy,
  output logic                             path_done,
  output logic                             plan_err,
  output logic [DIR_W-1:0]                 led_n
);

  localparam int SW        = $clog2(MAX_STEPS + 1);
  localparam int PW        = MAX_STEPS * DIR_W;
  localparam int CNT_MAX_A = (START_CYC > WAIT_TO) ? START_CYC : WAIT_TO;
  localparam int CNT_MAX   = (CNT_MAX_A > TICK_DIV) ? CNT_MAX_A : TICK_DIV;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TO - 1);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_END   = SW'(MAX_STEPS);
`ifdef DIR_SEQ_AUTO_REPLAN_EN
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_NODES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_RUN, S_END
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;       // shared REQ / WAIT / step timer
  logic [PW-1:0]        path_q, path_d;
  logic                 mode_q, mode_d;
  logic [SW-1:0]        step_q, step_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic                 valid_q, valid_d;
  logic                 start_q, start_d;
  logic [NODE_W-1:0]    s_q, s_d;
  logic [NODE_W-1:0]    e_q, e_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [DIR_W-1:0]     led_q, led_d;

  logic [DIR_W-1:0]     cur_slot;
  logic [DIR_W-1:0]     next_slot;
  logic [DIR_W-1:0]     first_slot;
  logic                 run_stop;
  logic                 advance;

  // Slot lookup; indices at or past MAX_STEPS read as the terminator code.
  function automatic logic [DIR_W-1:0] slot_at(input logic [PW-1:0] path,
                                               input logic [SW-1:0] idx);
    slot_at = '0;
    for (int k = 0; k < MAX_STEPS; k++) begin
      if (idx == SW'(k)) slot_at = path[k*DIR_W +: DIR_W];
    end
  endfunction

  assign cur_slot   = slot_at(path_q, step_q);
  assign next_slot  = slot_at(path_q, step_q + SW'(1));
  assign first_slot = slot_at(plan_path, '0);
  assign run_stop   = (step_q == STEP_END) || (cur_slot == '0);
  assign advance    = mode_q ? node_hit : (cnt_q == TICK_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: the default assignment first guarantees no path leaves state_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_REQ;
      S_REQ:  if (cnt_q == START_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (plan_done)               state_d = S_LOAD;
        else if (cnt_q == WAIT_LAST) state_d = S_IDLE;
      end
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (run_stop) state_d = S_END;
`ifdef DIR_SEQ_AUTO_REPLAN_EN
      S_END:  state_d = S_REQ;
`else
      S_END:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the counter, path store and all registered outputs.
  always_comb begin
    cnt_d   = cnt_q;
    path_d  = path_q;
    mode_d  = mode_q;
    step_d  = step_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    start_d = start_q;
    s_d     = s_q;
    e_d     = e_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          s_d     = s_node_in;
          e_d     = e_node_in;
          err_d   = 1'b0;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (cnt_q == START_LAST) begin
          start_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (plan_done) begin
          cnt_d = '0;
        end else if (cnt_q == WAIT_LAST) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        // Path and step source are frozen here for the whole run.
        path_d  = plan_path;
        mode_d  = adv_mode;
        step_d  = '0;
        cnt_d   = '0;
        dir_d   = first_slot;
        valid_d = (first_slot != '0);
      end
      S_RUN: begin
        if (run_stop) begin
          dir_d   = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (advance) begin
          step_d  = step_q + SW'(1);
          cnt_d   = '0;
          dir_d   = next_slot;
          valid_d = (next_slot != '0);
        end else if (!mode_q) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        dir_d   = '0;
        valid_d = 1'b0;
`ifdef DIR_SEQ_AUTO_REPLAN_EN
        s_d     = (s_q == NODE_LAST) ? '0 : s_q + 1'b1;
        e_d     = (e_q == NODE_LAST) ? '0 : e_q + 1'b1;
        start_d = 1'b1;
        cnt_d   = '0;
`endif
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    led_d  = ~dir_d;
  end

  // Datapath and output registers.
  // NOTE: the path store is reset along with everything else; it is only a
  // handful of flops, and a clean value keeps post-reset behaviour defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      path_q  <= '0;
      mode_q  <= 1'b0;
      step_q  <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      s_q     <= '0;
      e_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      path_q  <= path_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      start_q <= start_d;
      s_q     <= s_d;
      e_q     <= e_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign plan_start  = start_q;
  assign plan_s_node = s_q;
  assign plan_e_node = e_q;
  assign dir_out     = dir_q;
  assign dir_valid   = valid_q;
  assign step_idx    = step_q;
  assign busy        = busy_q;
  assign path_done   = done_q;
  assign plan_err    = err_q;
  assign led_n       = led_q;

endmodule
